vote_session_controller: RTL and testbench
==========================================

VOTE_SESSION_CONTROLLER -- requirements
Module: vote_session_controller

Interface
REQ-001 SHALL have parameter NUM_CAND, default 4, number of candidate vote inputs (2..8).
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-candidate vote counter.
REQ-003 SHALL have parameter TIMEOUT, default 1000, cycles an armed session waits for a vote before abandoning it.
REQ-004 SHALL have port clock  input  1  system clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mode  input  1  0 = voting mode, 1 = display mode.
REQ-007 SHALL have port arm  input  1  level from polling officer; rising edge enables exactly one vote.
REQ-008 SHALL have port vote_req  input  NUM_CAND  single-cycle vote pulses, one bit per candidate.
REQ-009 SHALL have port disp_sel  input  3  candidate index shown on count_out in display mode.
REQ-010 SHALL have port ready  output  1  high while session armed and accepting a vote.
REQ-011 SHALL have port vote_ack  output  NUM_CAND  one-hot, one-cycle pulse naming the candidate credited.
REQ-012 SHALL have port invalid  output  1  one-cycle pulse: multi-bit vote rejected.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse: armed session expired.
REQ-014 SHALL have port count_out  output  CNT_W  registered count of candidate disp_sel.
REQ-015 SHALL have port total_votes  output  16  registered total of credited votes.

Function
REQ-016 SHALL implement FSM states IDLE, ARMED, RECORD, LOCKOUT; reset state IDLE.
REQ-017 IDLE SHALL go to ARMED on the cycle after arm is sampled 1 having been 0 the prior cycle, only if mode=0; arm edges while mode=1 are discarded.
REQ-018 ARMED SHALL drive ready=1 and clear the timeout timer on entry, incrementing it each ARMED cycle.
REQ-019 ARMED with exactly one vote_req bit set SHALL latch that index and go to RECORD.
REQ-020 ARMED with two or more vote_req bits set in the same cycle SHALL pulse invalid, record nothing, go to LOCKOUT.
REQ-021 ARMED SHALL go to IDLE with timeout_err pulsed when the timer reaches TIMEOUT-1 with no vote_req bit set.
REQ-022 ARMED SHALL go to IDLE, no pulse, no vote, if mode becomes 1; mode takes priority over vote_req and timeout in the same cycle.
REQ-023 RECORD SHALL increment the latched candidate counter by 1, saturating at 2^CNT_W-1, increment total_votes saturating at 65535, pulse vote_ack for that index, and go to LOCKOUT; RECORD lasts exactly one cycle.
REQ-024 vote_ack SHALL still pulse when the counter is saturated.
REQ-025 LOCKOUT SHALL hold ready=0 and ignore vote_req, going to IDLE only when arm=0 and vote_req=0 in the same cycle.
REQ-026 vote_req bits arriving in IDLE, RECORD or LOCKOUT SHALL be ignored and never credited.
REQ-027 count_out SHALL equal the count of candidate disp_sel one cycle after sampling when mode=1, and 0 when mode=0 or disp_sel >= NUM_CAND.
REQ-028 Latency: vote_req sampled in ARMED at cycle N -> vote_ack and counter update visible at cycle N+2.

Reset
REQ-029 Reset SHALL force IDLE, clear all counters, total_votes, timer and arm-edge history, and drive ready, vote_ack, invalid, timeout_err, count_out to 0 on the next edge.
REQ-030 Reset SHALL override every state, including mid-RECORD; a vote interrupted by reset SHALL not be credited.

Verification
REQ-031 mode=0, arm 0->1, vote_req=0010 one cycle later -> ready=1 then vote_ack=0010 two cycles after vote, count[1]=1, total_votes=1.
REQ-032 Armed, vote_req=0101 -> invalid=1 one cycle, no counter change, state LOCKOUT until arm=0.
REQ-033 TIMEOUT=10, arm edge, no vote -> timeout_err pulse after 10 ARMED cycles, ready=0, later vote_req=0001 not counted.
REQ-034 CNT_W=2, four credited votes for candidate 3 -> count[3]=3, four vote_ack pulses, total_votes=4.
REQ-035 Votes for 0,0,2 then mode=1, disp_sel=0 then 2 then 5 -> count_out 2, 1, 0 with one-cycle lag.
REQ-036 Reset asserted in the RECORD cycle -> all outputs 0, count unchanged from 0, state IDLE.

Source files
------------

// File: rtl/vote_session_controller.sv
`default_nettype none
// ============================================================================
// Module      : vote_session_controller
// Description : Polling-booth session controller. A rising edge on arm opens
//               one voting session; exactly one single-candidate vote is
//               credited per session. Multi-bit votes are rejected, idle
//               sessions time out, and a display mode reads back the
//               per-candidate counts.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_session_controller #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                arm,
    input  logic [NUM_CAND-1:0] vote_req,
    input  logic [2:0]          disp_sel,
    output logic                ready,
    output logic [NUM_CAND-1:0] vote_ack,
    output logic                invalid,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    count_out,
    output logic [15:0]         total_votes
);

    // Timer only has to count up to TIMEOUT-1.
    localparam int                TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [15:0]       TOT_MAX  = 16'hFFFF;
    localparam logic [NUM_CAND-1:0] REQ_ONE = {{(NUM_CAND-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RECORD  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 arm_prev_q, arm_prev_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [NUM_CAND-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q [NUM_CAND];
    logic [CNT_W-1:0]     cnt_d [NUM_CAND];
    logic [15:0]          total_q, total_d;
    logic [NUM_CAND-1:0]  vote_ack_q, vote_ack_d;
    logic                 invalid_q, invalid_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]     count_out_q, count_out_d;

    logic                 req_any;
    logic                 req_multi;
    logic                 arm_rise;
    logic [CNT_W-1:0]     count_sel;

    // A vector has two or more bits set iff clearing its lowest set bit
    // leaves something behind.
    assign req_any   = |vote_req;
    assign req_multi = |(vote_req & (vote_req - REQ_ONE));
    assign arm_rise  = arm & ~arm_prev_q;
    assign arm_prev_d = arm;

    // Session state machine: next state, timer, latched candidate and pulses.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        sel_d         = sel_q;
        vote_ack_d    = '0;
        invalid_d     = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Edges seen while in display mode are simply lost.
                if (arm_rise && !mode) begin
                    state_d = ARMED;
                    timer_d = '0;
                end
            end
            ARMED: begin
                // Switching to display mode abandons the session silently
                // and wins over any vote or expiry in the same cycle.
                if (mode) begin
                    state_d = IDLE;
                end else if (req_multi) begin
                    invalid_d = 1'b1;
                    state_d   = LOCKOUT;
                end else if (req_any) begin
                    sel_d   = vote_req;
                    state_d = RECORD;
                end else if (timer_q == TMR_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RECORD: begin
                vote_ack_d = sel_q;
                state_d    = LOCKOUT;
            end
            LOCKOUT: begin
                // Officer must drop arm and the voter must release the
                // buttons before another session can start.
                if (!arm && !req_any) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Credit the latched candidate and the running total during RECORD.
    always_comb begin
        for (int i = 0; i < NUM_CAND; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        total_d = total_q;
        if (state_q == RECORD) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (sel_q[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            if (total_q != TOT_MAX) begin
                total_d = total_q + 16'd1;
            end
        end
    end

    // Display read-back; out-of-range selections fall through to zero.
    always_comb begin
        count_sel = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (disp_sel == 3'(i)) begin
                count_sel = cnt_q[i];
            end
        end
        count_out_d = mode ? count_sel : '0;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            arm_prev_q    <= 1'b0;
            timer_q       <= '0;
            sel_q         <= '0;
            for (int i = 0; i < NUM_CAND; i++) begin
                cnt_q[i] <= '0;
            end
            total_q       <= '0;
            vote_ack_q    <= '0;
            invalid_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            count_out_q   <= '0;
        end else begin
            state_q       <= state_d;
            arm_prev_q    <= arm_prev_d;
            timer_q       <= timer_d;
            sel_q         <= sel_d;
            for (int i = 0; i < NUM_CAND; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            total_q       <= total_d;
            vote_ack_q    <= vote_ack_d;
            invalid_q     <= invalid_d;
            timeout_err_q <= timeout_err_d;
            count_out_q   <= count_out_d;
        end
    end

    assign ready       = (state_q == ARMED);
    assign vote_ack    = vote_ack_q;
    assign invalid     = invalid_q;
    assign timeout_err = timeout_err_q;
    assign count_out   = count_out_q;
    assign total_votes = total_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_session_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vote_session_controller
// Description : Directed bench for vote_session_controller (4 candidates,
//               2-bit counters, 10-cycle timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_session_controller;

    localparam int NUM_CAND = 4;
    localparam int CNT_W    = 2;
    localparam int TIMEOUT  = 10;

    logic                clock;
    logic                reset;
    logic                mode;
    logic                arm;
    logic [NUM_CAND-1:0] vote_req;
    logic [2:0]          disp_sel;
    logic                ready;
    logic [NUM_CAND-1:0] vote_ack;
    logic                invalid;
    logic                timeout_err;
    logic [CNT_W-1:0]    count_out;
    logic [15:0]         total_votes;

    int tests_run;
    int tests_failed;

    vote_session_controller #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .arm         (arm),
        .vote_req    (vote_req),
        .disp_sel    (disp_sel),
        .ready       (ready),
        .vote_ack    (vote_ack),
        .invalid     (invalid),
        .timeout_err (timeout_err),
        .count_out   (count_out),
        .total_votes (total_votes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        arm      = 1'b0;
        mode     = 1'b0;
        vote_req = '0;
        disp_sel = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One complete session from IDLE: arm, vote, ack, release.
    task automatic cast_vote(input logic [NUM_CAND-1:0] v, input string tag);
        arm = 1'b1;
        tick();
        check({tag, "_ready"}, 32'(ready), 32'd1);
        vote_req = v;
        tick();
        vote_req = '0;
        check({tag, "_ack_early"}, 32'(vote_ack), 32'd0);
        tick();
        check({tag, "_ack"}, 32'(vote_ack), 32'(v));
        arm = 1'b0;
        tick();
        check({tag, "_ack_gone"}, 32'(vote_ack), 32'd0);
    endtask

    task automatic read_count(input logic [2:0] idx, input logic [CNT_W-1:0] exp, input string tag);
        mode     = 1'b1;
        disp_sel = idx;
        tick();
        check(tag, 32'(count_out), 32'(exp));
        mode     = 1'b0;
        disp_sel = '0;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset state
        apply_reset();
        check("rst_ready",   32'(ready),       32'd0);
        check("rst_ack",     32'(vote_ack),    32'd0);
        check("rst_invalid", 32'(invalid),     32'd0);
        check("rst_tmo",     32'(timeout_err), 32'd0);
        check("rst_count",   32'(count_out),   32'd0);
        check("rst_total",   32'(total_votes), 32'd0);

        // Single valid vote for candidate 1
        cast_vote(4'b0010, "v1");
        check("v1_total", 32'(total_votes), 32'd1);
        read_count(3'd1, 2'd1, "v1_cnt1");

        // Multi-bit vote rejected, then held in lockout while arm stays high
        arm = 1'b1;
        tick();
        check("inv_ready", 32'(ready), 32'd1);
        vote_req = 4'b0101;
        tick();
        vote_req = '0;
        check("inv_pulse",   32'(invalid), 32'd1);
        check("inv_ready0",  32'(ready),   32'd0);
        tick();
        check("inv_pulse_end", 32'(invalid), 32'd0);
        vote_req = 4'b0001;
        tick();
        vote_req = '0;
        tick();
        tick();
        check("lock_ack",   32'(vote_ack),    32'd0);
        check("lock_ready", 32'(ready),       32'd0);
        check("lock_total", 32'(total_votes), 32'd1);
        arm = 1'b0;
        tick();

        // Timeout: ten ARMED cycles with no vote
        arm = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        check("tmo_ready_c9", 32'(ready),       32'd1);
        check("tmo_none_c9",  32'(timeout_err), 32'd0);
        tick();
        check("tmo_pulse",    32'(timeout_err), 32'd1);
        check("tmo_ready0",   32'(ready),       32'd0);
        tick();
        check("tmo_pulse_end", 32'(timeout_err), 32'd0);
        vote_req = 4'b0001;
        tick();
        vote_req = '0;
        tick();
        tick();
        check("tmo_late_ack",   32'(vote_ack),    32'd0);
        check("tmo_late_total", 32'(total_votes), 32'd1);
        check("tmo_no_rearm",   32'(ready),       32'd0);
        arm = 1'b0;
        tick();
        read_count(3'd0, 2'd0, "tmo_cnt0");

        // Saturation: four votes for candidate 3 on a 2-bit counter
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            cast_vote(4'b1000, "sat");
        end
        check("sat_total", 32'(total_votes), 32'd4);
        read_count(3'd3, 2'd3, "sat_cnt3");

        // Display read-back with one-cycle lag and out-of-range select
        apply_reset();
        cast_vote(4'b0001, "d0a");
        cast_vote(4'b0001, "d0b");
        cast_vote(4'b0100, "d2");
        mode     = 1'b1;
        disp_sel = 3'd0;
        tick();
        check("disp_sel0", 32'(count_out), 32'd2);
        disp_sel = 3'd2;
        check("disp_lag", 32'(count_out), 32'd2);
        tick();
        check("disp_sel2", 32'(count_out), 32'd1);
        disp_sel = 3'd5;
        tick();
        check("disp_sel5", 32'(count_out), 32'd0);
        disp_sel = 3'd4;
        tick();
        check("disp_sel4", 32'(count_out), 32'd0);
        mode     = 1'b0;
        disp_sel = 3'd0;
        tick();
        check("disp_mode0", 32'(count_out), 32'd0);

        // Arm edge during display mode is discarded
        mode = 1'b1;
        arm  = 1'b1;
        tick();
        mode = 1'b0;
        tick();
        check("disp_arm_ignored", 32'(ready), 32'd0);
        arm = 1'b0;
        tick();

        // Mode wins over a vote in the same ARMED cycle
        arm = 1'b1;
        tick();
        mode     = 1'b1;
        vote_req = 4'b0010;
        tick();
        mode     = 1'b0;
        vote_req = '0;
        check("modeprio_ready", 32'(ready), 32'd0);
        tick();
        check("modeprio_ack",   32'(vote_ack),    32'd0);
        check("modeprio_inv",   32'(invalid),     32'd0);
        check("modeprio_total", 32'(total_votes), 32'd3);
        arm = 1'b0;
        tick();

        // Reset landing on the RECORD cycle
        apply_reset();
        arm = 1'b1;
        tick();
        vote_req = 4'b0001;
        tick();
        vote_req = '0;
        reset    = 1'b1;
        arm      = 1'b0;
        tick();
        reset = 1'b0;
        check("rrec_ack",   32'(vote_ack),    32'd0);
        check("rrec_ready", 32'(ready),       32'd0);
        check("rrec_total", 32'(total_votes), 32'd0);
        tick();
        check("rrec_ack2",  32'(vote_ack),    32'd0);
        read_count(3'd0, 2'd0, "rrec_cnt0");
        arm = 1'b1;
        tick();
        check("rrec_idle_rearm", 32'(ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
